spm_driver: RTL and testbench

//  Front/back end for the serial-parallel multiplier (spm). Accepts a signed operand pair on a

---
 rtl/spm_driver.sv | 98 +++++++++
 tb/tb_spm_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spm_driver.sv
// Host-side driver for a serial-parallel multiplier: holds A on the parallel bus,
// streams sign-extended B LSB-first, and gathers the serial product into a word.
module spm_driver #(
   parameter int SIZE  = 32,
   parameter int P_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   in_a,
   input  logic [SIZE-1:0]   in_b,
   output logic              spm_rst,
   output logic [SIZE-1:0]   spm_x,
   output logic              spm_y,
   input  logic              spm_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*SIZE-1:0] out_prod,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid, once raised, holds its payload until that edge, and ready may depend on state only.

   localparam int CW = $clog2(2*SIZE+P_LAT+1);
   localparam logic [CW-1:0] CNT_LAST = CW'(2*SIZE+P_LAT-1);
   localparam logic [CW-1:0] CNT_LAT  = CW'(P_LAT);

   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SIZE-1:0]   x_reg;
   logic [SIZE-1:0]   y_sh;
   logic [CW-1:0]     cnt;
   logic [2*SIZE-1:0] prod_sh;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (in_valid)        state_nxt = CLEAR;
         CLEAR:                      state_nxt = SHIFT;
         SHIFT: if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:  if (out_ready)       state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg   <= '0;
         y_sh    <= '0;
         cnt     <= '0;
         prod_sh <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg <= in_a;
                  y_sh  <= in_b;
               end
            end
            CLEAR: begin
               cnt     <= '0;
               prod_sh <= '0;
            end
            SHIFT: begin
               // Arithmetic shift keeps feeding the sign bit once B's own bits run out.
               y_sh <= {y_sh[SIZE-1], y_sh[SIZE-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt >= CNT_LAT) prod_sh <= {spm_p, prod_sh[2*SIZE-1:1]};
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      spm_rst   = (state == CLEAR);
      spm_x     = '0;
      spm_y     = 1'b0;
      out_valid = (state == DONE);
      out_prod  = '0;
      dbg_state = state;
      if (state == CLEAR || state == SHIFT) spm_x = x_reg;
      if (state == SHIFT)                   spm_y = y_sh[0];
      if (state == DONE)                    out_prod = prod_sh;
   end

endmodule

// File: tb/tb_spm_driver.sv
// Bench for spm_driver with a behavioural serial-parallel multiplier closing the loop;
// products are checked against signed A*B computed in the bench.
module tb_spm_driver;

  localparam int SIZE  = 8;
  localparam int P_LAT = 1;
  localparam int LAT   = 2*SIZE + P_LAT + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_a = '0;
  logic [SIZE-1:0] in_b = '0;
  logic            spm_rst;
  logic [SIZE-1:0] spm_x;
  logic            spm_y;
  logic            spm_p = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*SIZE-1:0] out_prod;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;

  spm_driver #(.SIZE(SIZE), .P_LAT(P_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .spm_rst(spm_rst), .spm_x(spm_x), .spm_y(spm_y),
    .spm_p(spm_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Serial-parallel multiplier: adds x<<k for each 1 bit of y, emits product bit k one clock later.
  logic [63:0] spm_acc = '0;
  int          spm_k = 0;
  always @(posedge clk) begin : spm_model
    logic [63:0] nxt;
    if (spm_rst) begin
      spm_acc <= '0;
      spm_k   <= 0;
      spm_p   <= 1'b0;
    end else begin
      nxt = spm_acc;
      if (spm_y && spm_k < 32) nxt = spm_acc + ({{(64-SIZE){spm_x[SIZE-1]}}, spm_x} << spm_k);
      spm_acc <= nxt;
      spm_p   <= nxt[spm_k[5:0]];
      if (spm_k < 63) spm_k <= spm_k + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input int in_gap, input int out_gap,
                       input bit early_ready, input bit hold_valid);
    int sa, sb, n, cyc;
    logic [2*SIZE-1:0] exp, held;
    sa  = $signed(a);
    sb  = $signed(b);
    exp = 16'(sa * sb);
    repeat (in_gap) tick();
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_timeout", 64'(n >= 100), 64'd0);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    if (early_ready) out_ready = 1'b1;
    chk("busy_ready", in_ready, 1'b0);
    chk("clear_pulse", spm_rst, 1'b1);
    chk("clear_x", spm_x, a);
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    chk("latency", cyc, LAT);
    chk("prod", out_prod, exp);
    chk("done_x", spm_x, '0);
    held = out_prod;
    if (out_gap > 0) out_ready = 1'b0;
    if (hold_valid) begin
      in_valid = 1'b1;
      in_a = 8'h09;
      in_b = 8'h09;
    end
    for (int i = 0; i < out_gap; i++) begin
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_prod", out_prod, held);
      chk("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_idle", dbg_state, 2'd0);
    in_valid = 1'b0;
    chk("back_ready", in_ready, 1'b1);
    chk("back_nvalid", out_valid, 1'b0);
    chk("back_prod", out_prod, '0);
  endtask

  initial begin
    int hits;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_spm_rst", spm_rst, 1'b0);
    chk("rst_spm_x", spm_x, '0);
    chk("rst_spm_y", spm_y, 1'b0);
    chk("rst_out_prod", out_prod, '0);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);

    do_op(8'd3,   8'd5,   0, 0, 1'b0, 1'b0);
    chk("dir_3x5", dut.prod_sh, 16'h000F);
    do_op(8'hFD,  8'd5,   0, 0, 1'b0, 1'b0);
    do_op(8'd5,   8'hFD,  1, 0, 1'b0, 1'b0);
    do_op(8'h80,  8'h80,  0, 0, 1'b0, 1'b0);
    do_op(8'h7F,  8'h7F,  2, 0, 1'b0, 1'b0);
    do_op(8'h00,  8'hFF,  0, 0, 1'b0, 1'b0);
    do_op(8'hFF,  8'hFF,  0, 0, 1'b1, 1'b0);
    do_op(8'h81,  8'h7F,  0, 3, 1'b0, 1'b0);
    do_op(8'd12,  8'd11,  0, 10, 1'b0, 1'b1);

    // Abort in the middle of SHIFT.
    in_valid = 1'b1;
    in_a = 8'd7;
    in_b = 8'd7;
    chk("abort_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("abort_in_shift", dbg_state, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", dbg_state, 2'd0);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid || spm_rst) hits++;
      tick();
    end
    chk("abort_quiet", hits, 0);
    do_op(8'd2, 8'd3, 0, 0, 1'b0, 1'b0);
    chk("post_abort_2x3", dut.prod_sh, 16'h0006);

    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
